fmap_window_gen: RTL and testbench
==================================

Name: fmap_window_gen

Overview:
- Stage-1 input windowing block, placed directly downstream of the pixel ROM feeder and upstream of the stage-1 convolution core.
- Accepts a row-major grayscale pixel stream (one pixel per valid cycle, no backpressure).
- Buffers K-1 full image rows and emits a flattened KxK window for every valid-convolution position (no padding), tagged with the output coordinate.
- Flags the end of each frame.

Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- K, 5, kernel (window) size
- BW, 8, pixel width; must equal ST1_I_F_BW

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  i_pixel valid this cycle; may deassert at any cycle (gaps allowed)
- i_pixel  in  BW  input pixel, row-major order
- o_valid  out  1  o_window and coordinates valid this cycle
- o_window  out  K*K*BW  window; element (r,c) at bits [(r*K+c)*BW +: BW]
- o_out_row  out  clog2(IMG_H-K+1)  output-map row of the current window
- o_out_col  out  clog2(IMG_W-K+1)  output-map column of the current window
- o_frame_done  out  1  one-cycle pulse, coincident with the last o_valid of a frame
- o_busy  out  1  high while a frame is partially received

Behaviour:
- Reset values:
  - all outputs 0; col/row counters 0; state IDLE.
  - Line-buffer RAM contents are not cleared. Stale data must never reach o_window while o_valid=1.
- Input counters:
  - in_col 0..IMG_W-1 and in_row 0..IMG_H-1 advance only on i_valid.
  - in_col wraps to 0 and increments in_row.
  - After pixel (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers:
  - K-1 row buffers, depth IMG_W, read and written at address in_col on i_valid.
  - Buffer j holds row in_row-1-j.
- Window register:
  - KxK shift register; on i_valid each row shifts left by one column.
  - The new rightmost column is {buf[K-2], ..., buf[0], i_pixel}, top to bottom.
- Window element mapping: element (r,c) is the pixel at image position (in_row-(K-1)+r, in_col-(K-1)+c).
  - r=0 is the top (oldest) row; c=0 is the leftmost column.
- o_valid:
  - Registered; asserted exactly 1 cycle after an accepted pixel with in_row>=K-1 and in_col>=K-1.
  - o_out_row = in_row-(K-1); o_out_col = in_col-(K-1), registered alongside o_valid.
- Output count and order: exactly (IMG_H-K+1)*(IMG_W-K+1) windows per frame (576 at defaults), in raster order.
- Stalls:
  - When i_valid=0, no state changes; o_valid=0 the following cycle.
  - o_window holds its last value.
- FSM:
  - IDLE -> ACTIVE on the first i_valid.
  - ACTIVE -> DONE on acceptance of the last frame pixel; o_frame_done=1 in the same output cycle as the final o_valid.
  - DONE -> IDLE unconditionally after 1 cycle.
  - If i_valid=1 while in DONE, that pixel is accepted as (0,0) of a new frame and the FSM goes to ACTIVE. Back-to-back frames must lose no pixel.
- o_busy = (state==ACTIVE).
- Row boundary: the window columns spanning a row wrap are never flagged valid. The column gate in_col>=K-1 guarantees this.
- Reset mid-frame: counters, FSM and outputs return to reset values immediately. The next i_valid is treated as pixel (0,0).
- No overflow condition exists, because there is no backpressure. The upstream feeder must not exceed 1 pixel/cycle, which is guaranteed by construction.

Decomposition:
- Add to defines_cnn_core.v: ST1_IMG_W, ST1_IMG_H, ST1_K, and ST1_WIN_BW = ST1_K*ST1_K*ST1_I_F_BW. Derive TOTAL_PIXELS from ST1_IMG_W*ST1_IMG_H.
- One sub-module, fmap_line_buffer: a single-port read-before-write RAM (depth IMG_W, width BW) with synchronous write. It is instantiated K-1 times as a chain: each buffer's output feeds the next buffer's input.

Test Plan:
- Ramp frame: 784 pixels, pixel = (row*28+col) mod 256, continuous i_valid.
  - Expect exactly 576 o_valid pulses.
  - The first window is at (0,0): element(0,0)=0, element(4,4)=116, element(0,4)=4.
  - The last window is at (23,23): element(4,4)=783 mod 256=15.
  - o_frame_done coincides with the final o_valid.
- Latency check: the o_valid for input pixel (4,4) rises exactly 1 cycle after that pixel's i_valid. No o_valid occurs for pixel (5,3).
- Random gaps: same ramp frame with i_valid randomly deasserted about 40% of the time.
  - Expect an identical window sequence and coordinates vs the scoreboard, and 576 pulses.
  - o_valid never asserts in a cycle following i_valid=0.
- Back-to-back frames: two ramp frames with the second offset by +50 and no idle cycle between them.
  - Expect 1152 windows and two o_frame_done pulses.
  - The first window of frame 2 has element(0,0)=50 with no frame-1 data.
- Reset mid-frame: assert reset_n=0 after pixel 400, then send a full ramp frame.
  - Expect all outputs at 0 during reset.
  - Then exactly 576 correct windows, with the first window element(4,4)=116.
- Non-default parameters: IMG_W=8, IMG_H=6, K=3.
  - Expect 24 windows; the last window is at o_out_row=3, o_out_col=5.

Source files
------------

// File: rtl/fmap_window_gen_pkg.sv
// Shared stage-1 windowing constants, FSM state type and counter-width helper.
package fmap_window_gen_pkg;

  localparam int ST1_I_F_BW   = 8;
  localparam int ST1_IMG_W    = 28;
  localparam int ST1_IMG_H    = 28;
  localparam int ST1_K        = 5;
  localparam int ST1_WIN_BW   = ST1_K * ST1_K * ST1_I_F_BW;
  localparam int TOTAL_PIXELS = ST1_IMG_W * ST1_IMG_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } win_state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_window_gen_line_buffer.sv
// One image row of storage: single-port RAM, asynchronous read-before-write, synchronous write.
module fmap_line_buffer #(
  parameter int DEPTH = 28,
  parameter int BW    = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [BW-1:0] wdata,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; readers gate stale rows by position.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/fmap_window_gen.sv
// Stage-1 KxK sliding-window generator: buffers K-1 rows and emits one window per valid-convolution position.
module fmap_window_gen
  import fmap_window_gen_pkg::*;
#(
  parameter int IMG_W = ST1_IMG_W,
  parameter int IMG_H = ST1_IMG_H,
  parameter int K     = ST1_K,
  parameter int BW    = ST1_I_F_BW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_valid,
  input  logic [BW-1:0]                 i_pixel,
  output logic                          o_valid,
  output logic [K*K*BW-1:0]             o_window,
  output logic [cnt_w(IMG_H-K+1)-1:0]   o_out_row,
  output logic [cnt_w(IMG_W-K+1)-1:0]   o_out_col,
  output logic                          o_frame_done,
  output logic                          o_busy
);

  localparam int COL_W  = cnt_w(IMG_W);
  localparam int ROW_W  = cnt_w(IMG_H);
  localparam int OROW_W = cnt_w(IMG_H - K + 1);
  localparam int OCOL_W = cnt_w(IMG_W - K + 1);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] FIRST_ROW = ROW_W'(K - 1);

  win_state_e       state;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic [BW-1:0]    lb_in   [K-1];
  logic [BW-1:0]    lb_out  [K-1];
  logic [BW-1:0]    new_col [K];
  logic [BW-1:0]    win     [K][K];
  logic             last_pix;
  logic             win_hit;

  assign last_pix = (in_row == LAST_ROW) && (in_col == LAST_COL);
  assign win_hit  = i_valid && (in_row >= FIRST_ROW) && (in_col >= FIRST_COL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_col <= '0;
      in_row <= '0;
    end else if (i_valid) begin
      if (in_col == LAST_COL) begin
        in_col <= '0;
        in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
      end else begin
        in_col <= in_col + COL_W'(1);
      end
    end
  end

  // Buffer j is fed by buffer j-1's old content, so it always holds row in_row-1-j.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_in[j] = i_pixel;
    end else begin : g_chain
      assign lb_in[j] = lb_out[j-1];
    end

    fmap_line_buffer #(
      .DEPTH(IMG_W),
      .BW   (BW),
      .AW   (COL_W)
    ) u_lb (
      .clk  (clk),
      .wr_en(i_valid),
      .addr (in_col),
      .wdata(lb_in[j]),
      .rdata(lb_out[j])
    );
  end

  always_comb begin
    new_col = '{default: '0};
    for (int unsigned r = 0; r < K - 1; r++) begin
      new_col[r] = lb_out[K-2-r];
    end
    new_col[K-1] = i_pixel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (i_valid) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= new_col[r];
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        o_window[(r*K+c)*BW +: BW] = win[r][c];
      end
    end
  end

  // A pixel arriving in DONE is pixel (0,0) of the next frame, so DONE never drops input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_out_row    <= '0;
      o_out_col    <= '0;
    end else begin
      o_valid      <= win_hit;
      o_frame_done <= i_valid && last_pix;
      if (win_hit) begin
        o_out_row <= OROW_W'(in_row - FIRST_ROW);
        o_out_col <= OCOL_W'(in_col - FIRST_COL);
      end
      unique case (state)
        IDLE:    if (i_valid) state <= last_pix ? DONE : ACTIVE;
        ACTIVE:  if (i_valid && last_pix) state <= DONE;
        DONE:    state <= i_valid ? (last_pix ? DONE : ACTIVE) : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state == ACTIVE);

  a_done_with_valid: assert property (@(posedge clk) disable iff (!reset_n)
    o_frame_done |-> o_valid);

  a_valid_after_input: assert property (@(posedge clk) disable iff (!reset_n)
    o_valid |-> $past(i_valid));

endmodule

// File: tb/tb_fmap_window_gen.sv
// Bench for fmap_window_gen: default-size DUT against a frame-array model, plus an 8x6/K=3 instance checked in closed form.
`define CHK(n, a, e) chk(n, 200'(a), 200'(e))

module tb_fmap_window_gen;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KK = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_valid = 1'b0;
  logic [7:0]   a_pixel = '0;
  logic         a_o_valid, a_o_done, a_o_busy;
  logic [199:0] a_o_window;
  logic [4:0]   a_o_row, a_o_col;

  logic         b_valid = 1'b0;
  logic [7:0]   b_pixel = '0;
  logic         b_o_valid, b_o_done, b_o_busy;
  logic [71:0]  b_o_window;
  logic [1:0]   b_o_row;
  logic [2:0]   b_o_col;

  fmap_window_gen u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (a_valid),
    .i_pixel     (a_pixel),
    .o_valid     (a_o_valid),
    .o_window    (a_o_window),
    .o_out_row   (a_o_row),
    .o_out_col   (a_o_col),
    .o_frame_done(a_o_done),
    .o_busy      (a_o_busy)
  );

  fmap_window_gen #(.IMG_W(8), .IMG_H(6), .K(3), .BW(8)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid     (b_valid),
    .i_pixel     (b_pixel),
    .o_valid     (b_o_valid),
    .o_window    (b_o_window),
    .o_out_row   (b_o_row),
    .o_out_col   (b_o_col),
    .o_frame_done(b_o_done),
    .o_busy      (b_o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [199:0] act, logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] elem(logic [199:0] w, int r, int c);
    return w[(r*KK+c)*8 +: 8];
  endfunction

  function automatic logic [7:0] ramp(int idx, int off);
    return 8'((idx + off) % 256);
  endfunction

  // Reference model: the frame as an image array, pixel p of the frame at (p/W, p%W).
  logic [7:0]   frame [H][W];
  int           p = 0;
  int           mrow, mcol;
  logic         exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
  int           exp_row = 0, exp_col = 0;
  logic [199:0] exp_win = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p = 0;
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (a_valid) begin
        mrow = p / W;
        mcol = p % W;
        frame[mrow][mcol] = a_pixel;
        if (mrow >= KK - 1 && mcol >= KK - 1) begin
          exp_valid = 1'b1;
          exp_row   = mrow - (KK - 1);
          exp_col   = mcol - (KK - 1);
          for (int r = 0; r < KK; r++)
            for (int c = 0; c < KK; c++)
              exp_win[(r*KK+c)*8 +: 8] = frame[mrow-(KK-1)+r][mcol-(KK-1)+c];
        end
        p = (p + 1) % (W * H);
        exp_done = (p == 0);
      end
      exp_busy = (p != 0);
    end
  end

  int           a_win_cnt = 0, a_done_cnt = 0;
  logic [199:0] first_win = '0, last_win = '0;
  logic [4:0]   last_row = '0, last_col = '0;

  always @(negedge clk) begin
    n_checks += 3;
    if (a_o_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL a_o_valid: got %0b, expected %0b (t=%0t)", a_o_valid, exp_valid, $time);
    end
    if (a_o_done !== exp_done) begin
      n_fail++;
      $display("FAIL a_o_frame_done: got %0b, expected %0b (t=%0t)", a_o_done, exp_done, $time);
    end
    if (a_o_busy !== exp_busy) begin
      n_fail++;
      $display("FAIL a_o_busy: got %0b, expected %0b (t=%0t)", a_o_busy, exp_busy, $time);
    end
    if (exp_valid) begin
      n_checks += 3;
      if (a_o_row !== 5'(exp_row)) begin
        n_fail++;
        $display("FAIL a_o_out_row: got %0d, expected %0d (t=%0t)", a_o_row, exp_row, $time);
      end
      if (a_o_col !== 5'(exp_col)) begin
        n_fail++;
        $display("FAIL a_o_out_col: got %0d, expected %0d (t=%0t)", a_o_col, exp_col, $time);
      end
      if (a_o_window !== exp_win) begin
        n_fail++;
        $display("FAIL a_o_window: got %0h, expected %0h (t=%0t)", a_o_window, exp_win, $time);
      end
    end
    if (a_o_valid === 1'b1) begin
      a_win_cnt++;
      if (a_o_row == 5'd0 && a_o_col == 5'd0) first_win = a_o_window;
      last_win = a_o_window;
      last_row = a_o_row;
      last_col = a_o_col;
    end
    if (a_o_done === 1'b1) a_done_cnt++;
  end

  // Small instance: ramp pixel value equals its raster index, so windows are closed-form.
  int          b_cnt = 0, b_done_cnt = 0, erow, ecol;
  logic [71:0] ew;
  logic [1:0]  b_last_row = '0;
  logic [2:0]  b_last_col = '0;

  always @(negedge clk) begin
    if (b_o_valid === 1'b1) begin
      erow = b_cnt / 6;
      ecol = b_cnt % 6;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          ew[(r*3+c)*8 +: 8] = 8'((erow + r) * 8 + ecol + c);
      n_checks += 3;
      if (b_o_row !== 2'(erow)) begin
        n_fail++;
        $display("FAIL b_o_out_row: got %0d, expected %0d (t=%0t)", b_o_row, erow, $time);
      end
      if (b_o_col !== 3'(ecol)) begin
        n_fail++;
        $display("FAIL b_o_out_col: got %0d, expected %0d (t=%0t)", b_o_col, ecol, $time);
      end
      if (b_o_window !== ew) begin
        n_fail++;
        $display("FAIL b_o_window: got %0h, expected %0h (t=%0t)", b_o_window, ew, $time);
      end
      b_last_row = b_o_row;
      b_last_col = b_o_col;
      b_cnt++;
    end
    if (b_o_done === 1'b1) begin
      b_done_cnt++;
      n_checks++;
      if (b_o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b_done_with_valid: got %0b, expected 1 (t=%0t)", b_o_valid, $time);
      end
    end
  end

  task automatic send(input logic v, input logic [7:0] px);
    @(posedge clk);
    #1;
    a_valid = v;
    a_pixel = px;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 8'd0);
  endtask

  task automatic send_frame(input int off, input int gap_pct, input bit rnd);
    for (int i = 0; i < W * H; i++) begin
      while ($urandom_range(99) < gap_pct) send(1'b0, 8'd0);
      send(1'b1, rnd ? 8'($urandom) : ramp(i, off));
    end
  endtask

  task automatic check_all_zero(input string tag);
    `CHK({tag, "_o_valid"}, a_o_valid, 1'b0);
    `CHK({tag, "_o_window"}, a_o_window, 200'd0);
    `CHK({tag, "_o_out_row"}, a_o_row, 5'd0);
    `CHK({tag, "_o_out_col"}, a_o_col, 5'd0);
    `CHK({tag, "_o_frame_done"}, a_o_done, 1'b0);
    `CHK({tag, "_o_busy"}, a_o_busy, 1'b0);
  endtask

  int base_w, base_d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    `CHK("reset_b_o_valid", b_o_valid, 1'b0);
    `CHK("reset_b_o_busy", b_o_busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Small-parameter instance: 8x6 frame, K=3
    for (int i = 0; i < 48; i++) begin
      @(posedge clk);
      #1;
      b_valid = 1'b1;
      b_pixel = 8'(i);
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (b_cnt != 24) begin
      n_fail++;
      $display("FAIL b_window_count: got %0d, expected 24", b_cnt);
    end
    if (b_last_row != 2'd3) begin
      n_fail++;
      $display("FAIL b_last_row: got %0d, expected 3", b_last_row);
    end
    if (b_last_col != 3'd5) begin
      n_fail++;
      $display("FAIL b_last_col: got %0d, expected 5", b_last_col);
    end
    if (b_done_cnt != 1) begin
      n_fail++;
      $display("FAIL b_frame_done_count: got %0d, expected 1", b_done_cnt);
    end

    // Directed ramp frame with latency and boundary probes
    base_w = a_win_cnt;
    base_d = a_done_cnt;
    for (int i = 0; i < W * H; i++) begin
      send(1'b1, ramp(i, 0));
      if (i == 4*W + 4 || i == 5*W + 3 || i == W*H - 1) begin
        send(1'b0, 8'd0);
        @(negedge clk);
        if (i == 4*W + 4) begin
          `CHK("lat_valid_4_4", a_o_valid, 1'b1);
          `CHK("first_row", a_o_row, 5'd0);
          `CHK("first_col", a_o_col, 5'd0);
          `CHK("first_elem_0_0", elem(a_o_window, 0, 0), 8'd0);
          `CHK("first_elem_4_4", elem(a_o_window, 4, 4), 8'd116);
          `CHK("first_elem_0_4", elem(a_o_window, 0, 4), 8'd4);
        end else if (i == 5*W + 3) begin
          `CHK("no_valid_5_3", a_o_valid, 1'b0);
        end else begin
          `CHK("last_valid", a_o_valid, 1'b1);
          `CHK("last_done", a_o_done, 1'b1);
          `CHK("last_row", a_o_row, 5'd23);
          `CHK("last_col", a_o_col, 5'd23);
          `CHK("last_elem_4_4", elem(a_o_window, 4, 4), 8'd15);
        end
      end
    end
    idle(3);
    n_checks += 2;
    if (a_win_cnt - base_w != 576) begin
      n_fail++;
      $display("FAIL ramp_window_count: got %0d, expected 576", a_win_cnt - base_w);
    end
    if (a_done_cnt - base_d != 1) begin
      n_fail++;
      $display("FAIL ramp_done_count: got %0d, expected 1", a_done_cnt - base_d);
    end

    // Ramp frame with ~40% input gaps
    base_w = a_win_cnt;
    base_d = a_done_cnt;
    send_frame(0, 40, 1'b0);
    idle(3);
    `CHK("gap_window_count", a_win_cnt - base_w, 576);
    `CHK("gap_done_count", a_done_cnt - base_d, 1);
    `CHK("gap_last_row", last_row, 5'd23);
    `CHK("gap_last_col", last_col, 5'd23);

    // Random pixel data with gaps
    base_w = a_win_cnt;
    send_frame(0, 30, 1'b1);
    idle(3);
    `CHK("rand_window_count", a_win_cnt - base_w, 576);

    // Back-to-back frames, second offset by +50
    base_w = a_win_cnt;
    base_d = a_done_cnt;
    send_frame(0, 0, 1'b0);
    send_frame(50, 0, 1'b0);
    idle(3);
    `CHK("b2b_window_count", a_win_cnt - base_w, 1152);
    `CHK("b2b_done_count", a_done_cnt - base_d, 2);
    `CHK("b2b_f2_elem_0_0", elem(first_win, 0, 0), 8'd50);
    `CHK("b2b_f2_elem_4_4", elem(first_win, 4, 4), 8'd166);

    // Reset in the middle of a frame
    for (int i = 0; i < 400; i++) send(1'b1, ramp(i, 0));
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    reset_n = 1'b0;
    #3;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    check_all_zero("midrst_hold");
    reset_n = 1'b1;
    base_w = a_win_cnt;
    base_d = a_done_cnt;
    send_frame(0, 0, 1'b0);
    idle(3);
    `CHK("rst_window_count", a_win_cnt - base_w, 576);
    `CHK("rst_done_count", a_done_cnt - base_d, 1);
    `CHK("rst_first_elem_4_4", elem(first_win, 4, 4), 8'd116);
    `CHK("rst_first_elem_0_0", elem(first_win, 0, 0), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
